conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/conv_sequencer_if.sv | 31 +++
 rtl/conv_addr_gen.sv | 74 +++++++
 rtl/conv_sequencer.sv | 139 +++++++++++++
 tb/tb_conv_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and datapath-control bit map for the convolution sequencer
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_ADD,
        S_STORE,
        S_FINISH
    } state_t;

    localparam int CTL_RAM_EN   = 0;
    localparam int CTL_ROM_EN   = 1;
    localparam int CTL_MULT_EN  = 2;
    localparam int CTL_ADD_EN   = 3;
    localparam int CTL_STORE_EN = 4;
    localparam int CTL_DONE     = 5;
    localparam int CTL_W        = 6;

    typedef logic [CTL_W-1:0] ctl_t;

    // Which control strobes each phase owns; everything else stays low.
    function automatic ctl_t phase_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_LOAD: begin
                c[CTL_RAM_EN] = 1'b1;
                c[CTL_ROM_EN] = 1'b1;
            end
            S_MULT:   c[CTL_MULT_EN]  = 1'b1;
            S_ADD:    c[CTL_ADD_EN]   = 1'b1;
            S_STORE:  c[CTL_STORE_EN] = 1'b1;
            S_FINISH: c[CTL_DONE]     = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// rtl/conv_sequencer_if.sv - control, RAM/ROM and datapath strobes of the convolution sequencer
interface conv_sequencer_if #(
    parameter int ADDR_W     = 10,
    parameter int ROM_W      = 4,
    parameter int ADD_LEVELS = 4
) ();
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  ram_en;
    logic [ADDR_W-1:0]     ram_addr;
    logic                  rom_en;
    logic [ROM_W-1:0]      rom_addr;
    logic                  dp_mult_en;
    logic [ADD_LEVELS-1:0] dp_add_lvl;
    logic                  dp_store_en;
    logic [ADDR_W-1:0]     out_addr;

    modport master (
        input  start, abort,
        output busy, done, ram_en, ram_addr, rom_en, rom_addr,
               dp_mult_en, dp_add_lvl, dp_store_en, out_addr
    );

    modport slave (
        output start, abort,
        input  busy, done, ram_en, ram_addr, rom_en, rom_addr,
               dp_mult_en, dp_add_lvl, dp_store_en, out_addr
    );
endinterface

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - window row/col and kernel tap counters with RAM and result address generation
module conv_addr_gen #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int K      = 3,
    parameter int ADDR_W = 10,
    parameter int TAP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              tap_step,
    input  logic              win_step,
    output logic [TAP_W-1:0]  tap,
    output logic              last_tap,
    output logic              last_win,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [ADDR_W-1:0] out_addr
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] tap_row;
    logic [ADDR_W-1:0] tap_col;

    // Tap row/col are tracked directly so no divider is needed for t/K and t%K.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap     <= '0;
            tap_row <= '0;
            tap_col <= '0;
            row     <= '0;
            col     <= '0;
        end else if (clear) begin
            tap     <= '0;
            tap_row <= '0;
            tap_col <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            if (tap_step) begin
                if (last_tap) begin
                    tap     <= '0;
                    tap_row <= '0;
                    tap_col <= '0;
                end else begin
                    tap <= tap + 1'b1;
                    if (tap_col == ADDR_W'(K - 1)) begin
                        tap_col <= '0;
                        tap_row <= tap_row + 1'b1;
                    end else begin
                        tap_col <= tap_col + 1'b1;
                    end
                end
            end
            if (win_step) begin
                if (col == ADDR_W'(OUT_W - 1)) begin
                    col <= '0;
                    row <= last_win ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign last_tap = (tap == TAP_W'(K * K - 1));
    assign last_win = (row == ADDR_W'(OUT_H - 1)) && (col == ADDR_W'(OUT_W - 1));
    assign ram_addr = (row + tap_row) * ADDR_W'(IMG_W) + col + tap_col;
    assign out_addr = row * ADDR_W'(OUT_W) + col;

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - phase FSM sequencing load, multiply, adder tree and store for each output window
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W       = 16,
    parameter int IMG_H       = 16,
    parameter int K           = 3,
    parameter int ADDR_W      = 10,
    parameter int MULT_CYCLES = 16,
    parameter int ADD_LEVELS  = 4,
    parameter int ADD_CYCLES  = 8
) (
    input  logic            clk,
    input  logic            reset,
    conv_sequencer_if.master bus
);
    localparam int ROM_W   = $clog2(K * K);
    localparam int CNT_MAX = (MULT_CYCLES > ADD_CYCLES) ? MULT_CYCLES : ADD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int LVL_W   = (ADD_LEVELS > 1) ? $clog2(ADD_LEVELS) : 1;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [LVL_W-1:0]  lvl;
    logic [LVL_W-1:0]  lvl_next;
    logic              tap_step;
    logic              win_step;
    logic              ag_clear;
    logic [ROM_W-1:0]  tap;
    logic              last_tap;
    logic              last_win;
    logic [ADDR_W-1:0] ag_ram_addr;
    logic [ADDR_W-1:0] ag_out_addr;
    ctl_t              ctl;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .ADDR_W (ADDR_W),
        .TAP_W  (ROM_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (ag_clear),
        .tap_step (tap_step),
        .win_step (win_step),
        .tap      (tap),
        .last_tap (last_tap),
        .last_win (last_win),
        .ram_addr (ag_ram_addr),
        .out_addr (ag_out_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            lvl   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            lvl   <= lvl_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lvl_next   = lvl;
        tap_step   = 1'b0;
        win_step   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                lvl_next = '0;
                if (bus.start && !bus.abort) state_next = S_LOAD;
            end
            S_LOAD: begin
                tap_step = 1'b1;
                if (last_tap) state_next = S_MULT;
            end
            S_MULT: begin
                if (cnt == CNT_W'(MULT_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = S_ADD;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_ADD: begin
                if (cnt == CNT_W'(ADD_CYCLES - 1)) begin
                    cnt_next = '0;
                    if (lvl == LVL_W'(ADD_LEVELS - 1)) begin
                        lvl_next   = '0;
                        state_next = S_STORE;
                    end else begin
                        lvl_next = lvl + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_STORE: begin
                win_step   = 1'b1;
                state_next = last_win ? S_FINISH : S_LOAD;
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        // Abort outranks every other transition and freezes the address counters.
        if (bus.abort && state != S_IDLE) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            lvl_next   = '0;
            tap_step   = 1'b0;
            win_step   = 1'b0;
        end
    end

    assign ag_clear = (state == S_IDLE) || bus.abort;
    assign ctl      = phase_ctl(state);

    always_comb begin
        bus.busy        = (state != S_IDLE);
        bus.done        = ctl[CTL_DONE] && !bus.abort;
        bus.ram_en      = ctl[CTL_RAM_EN];
        bus.ram_addr    = ctl[CTL_RAM_EN] ? ag_ram_addr : '0;
        bus.rom_en      = ctl[CTL_ROM_EN];
        bus.rom_addr    = ctl[CTL_ROM_EN] ? tap : '0;
        bus.dp_mult_en  = ctl[CTL_MULT_EN];
        bus.dp_add_lvl  = ctl[CTL_ADD_EN] ? (ADD_LEVELS'(1) << lvl) : '0;
        bus.dp_store_en = ctl[CTL_STORE_EN] && !bus.abort;
        bus.out_addr    = ctl[CTL_STORE_EN] ? ag_out_addr : '0;
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - self-checking bench for conv_sequencer with a per-cycle behavioural model
module tb_conv_sequencer;

    localparam int MC = 16;
    localparam int AL = 4;
    localparam int AC = 8;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        ram_en;
        logic [15:0] ram_addr;
        logic        rom_en;
        logic [7:0]  rom_addr;
        logic        mult;
        logic [7:0]  add_lvl;
        logic        store;
        logic [15:0] out_addr;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv_sequencer_if #(.ADDR_W(10), .ROM_W(4), .ADD_LEVELS(4)) bus0 ();
    conv_sequencer_if #(.ADDR_W(10), .ROM_W(2), .ADD_LEVELS(4)) bus1 ();

    conv_sequencer dut0 (.clk(clk), .reset(reset), .bus(bus0));
    conv_sequencer #(.IMG_W(4), .IMG_H(4), .K(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    obs_t got0, got1;
    assign got0 = {bus0.busy, bus0.done, bus0.ram_en, 16'(bus0.ram_addr), bus0.rom_en, 8'(bus0.rom_addr),
                   bus0.dp_mult_en, 8'(bus0.dp_add_lvl), bus0.dp_store_en, 16'(bus0.out_addr)};
    assign got1 = {bus1.busy, bus1.done, bus1.ram_en, 16'(bus1.ram_addr), bus1.rom_en, 8'(bus1.rom_addr),
                   bus1.dp_mult_en, 8'(bus1.dp_add_lvl), bus1.dp_store_en, 16'(bus1.out_addr)};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int pass_len(input int iw, input int ih, input int k);
        return (iw - k + 1) * (ih - k + 1) * (k * k + MC + AL * AC + 1);
    endfunction

    // Outputs derived from the pass timeline: window w occupies lat cycles, then one finish cycle.
    function automatic obs_t model_out(input int iw, input int ih, input int k,
                                       input bit act, input int p, input bit ab);
        obs_t o;
        int ow, lat, w, r, row, col;
        o = '0;
        if (!act) return o;
        o.busy = 1'b1;
        ow  = iw - k + 1;
        lat = k * k + MC + AL * AC + 1;
        if (p >= pass_len(iw, ih, k)) begin
            o.done = !ab;
            return o;
        end
        w   = p / lat;
        r   = p % lat;
        row = w / ow;
        col = w % ow;
        if (r < k * k) begin
            o.ram_en   = 1'b1;
            o.rom_en   = 1'b1;
            o.rom_addr = 8'(r);
            o.ram_addr = 16'((row + r / k) * iw + col + r % k);
        end else if (r < k * k + MC) begin
            o.mult = 1'b1;
        end else if (r < k * k + MC + AL * AC) begin
            o.add_lvl = 8'(1 << ((r - k * k - MC) / AC));
        end else begin
            o.store    = !ab;
            o.out_addr = 16'(row * ow + col);
        end
        return o;
    endfunction

    bit m_act0 = 0, m_act1 = 0;
    int m_p0 = 0, m_p1 = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act0 = 0; m_p0 = 0;
            m_act1 = 0; m_p1 = 0;
        end else begin
            if (m_act0) begin
                if (bus0.abort || m_p0 >= pass_len(16, 16, 3)) m_act0 = 0;
                else m_p0++;
            end else if (bus0.start && !bus0.abort) begin
                m_act0 = 1; m_p0 = 0;
            end
            if (m_act1) begin
                if (bus1.abort || m_p1 >= pass_len(4, 4, 2)) m_act1 = 0;
                else m_p1++;
            end else if (bus1.start && !bus1.abort) begin
                m_act1 = 1; m_p1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model0", got0, model_out(16, 16, 3, m_act0, m_p0, bus0.abort));
        chk("model1", got1, model_out(4, 4, 2, m_act1, m_p1, bus1.abort));
    end

    int q_ram0[$], q_rom0[$], q_st0[$], q_ram1[$], q_st1[$];
    int done_cnt0 = 0, done_cnt1 = 0, done_cyc0 = 0, load_cyc0 = 0;
    logic busy_prev0 = 1'b0;

    always @(negedge clk) begin
        if (bus0.ram_en) begin q_ram0.push_back(int'(bus0.ram_addr)); q_rom0.push_back(int'(bus0.rom_addr)); end
        if (bus0.dp_store_en) q_st0.push_back(int'(bus0.out_addr));
        if (bus0.done) begin done_cnt0++; done_cyc0 = cyc; end
        if (bus0.busy && !busy_prev0) load_cyc0 = cyc;
        busy_prev0 = bus0.busy;
        if (bus1.ram_en) q_ram1.push_back(int'(bus1.ram_addr));
        if (bus1.dp_store_en) q_st1.push_back(int'(bus1.out_addr));
        if (bus1.done) done_cnt1++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_ram0.delete(); q_rom0.delete(); q_st0.delete();
        done_cnt0 = 0;
    endtask

    task automatic wait_done0(input string name);
        int n;
        n = 0;
        while (!bus0.done && n < 12000) begin @(negedge clk); n++; end
        chk(name, bus0.done, 1'b1);
    endtask

    initial begin
        int seq_ok;
        int exp_ram[9];
        int exp_w8[4];
        int n;
        exp_ram = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        exp_w8  = '{10, 11, 14, 15};
        bus0.start = 0; bus0.abort = 0;
        bus1.start = 0; bus1.abort = 0;
        tick(); tick(); tick();
        chk("reset_outputs0", got0, '0);
        chk("reset_outputs1", got1, '0);
        reset = 1'b1;
        tick();

        // Full default pass plus the small 4x4/K=2 pass in parallel.
        clear_log();
        bus0.start = 1; bus1.start = 1;
        tick();
        bus0.start = 0; bus1.start = 0;
        @(negedge clk);
        chk("busy_after_start", bus0.busy, 1'b1);
        wait_done0("pass1_done_seen");
        tick(); tick();
        chk("pass1_store_count", q_st0.size(), 196);
        seq_ok = 1;
        foreach (q_st0[i]) if (q_st0[i] != i) seq_ok = 0;
        chk("pass1_store_order", seq_ok, 1);
        chk("pass1_done_count", done_cnt0, 1);
        chk("pass1_done_latency", done_cyc0 - load_cyc0, 196 * 58);
        chk("pass1_idle_after", bus0.busy, 1'b0);
        seq_ok = 1;
        for (int i = 0; i < 9; i++)
            if (q_ram0[i] != exp_ram[i] || q_rom0[i] != i) seq_ok = 0;
        chk("first_window_addrs", seq_ok, 1);
        chk("row1_col0_first_ram", q_ram0[14 * 9], 16);
        chk("row1_col0_out_addr", q_st0[14], 14);
        chk("small_store_count", q_st1.size(), 9);
        chk("small_done_count", done_cnt1, 1);
        seq_ok = 1;
        for (int i = 0; i < 4; i++) if (q_ram1[32 + i] != exp_w8[i]) seq_ok = 0;
        chk("small_w22_addrs", seq_ok, 1);

        // Abort during the third adder level.
        clear_log();
        bus0.start = 1; bus0.abort = 1;
        tick();
        bus0.start = 0; bus0.abort = 0;
        chk("start_with_abort_idle", bus0.busy, 1'b0);
        bus0.start = 1;
        tick();
        bus0.start = 0;
        n = 0;
        while (bus0.dp_add_lvl != 4'b0100 && n < 200) begin @(negedge clk); n++; end
        chk("reach_add_lvl2", bus0.dp_add_lvl, 4'b0100);
        tick();
        bus0.abort = 1;
        tick();
        bus0.abort = 0;
        @(negedge clk);
        chk("abort_busy_low", bus0.busy, 1'b0);
        chk("abort_no_done", done_cnt0, 0);
        chk("abort_no_store", q_st0.size(), 0);
        tick();
        bus0.start = 1;
        tick();
        bus0.start = 0;
        n = 0;
        while (q_st0.size() == 0 && n < 200) begin @(negedge clk); n++; end
        chk("restart_first_out_addr", (q_st0.size() > 0) ? q_st0[0] : -1, 0);

        // Asynchronous reset in the middle of MULT.
        n = 0;
        while (!bus0.dp_mult_en && n < 200) begin @(negedge clk); n++; end
        chk("reach_mult", bus0.dp_mult_en, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", got0, '0);
        tick(); tick();
        chk("reset_no_done", done_cnt0, 0);
        reset = 1'b1;
        tick();

        // Repeated start while busy must not disturb the pass.
        clear_log();
        bus0.start = 1;
        tick();
        for (int i = 0; i < 300; i++) begin
            bus0.start = (i % 3 == 0);
            tick();
        end
        bus0.start = 0;
        wait_done0("pass2_done_seen");
        tick(); tick();
        chk("pass2_store_count", q_st0.size(), 196);
        chk("pass2_done_count", done_cnt0, 1);
        chk("pass2_done_latency", done_cyc0 - load_cyc0, 196 * 58);
        chk("pass2_idle_after", bus0.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
